// File: rtl/eater_pkg.sv
// Shared types and control-word bit positions for the eater core sequencer.
package eater_pkg;

    localparam int CW_WIDTH = 16;

    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    typedef logic [CW_WIDTH-1:0] cw_t;
    typedef logic [2:0]          step_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {
        S_RUN,
        S_HALT
    } seq_state_t;

    function automatic cw_t cw_bit(input int unsigned idx);
        return cw_t'(1) << idx;
    endfunction

endpackage

// File: rtl/eater_microcode_rom.sv
// Combinational microcode table: (opcode, T-state, flags) -> 16-bit control word.
module eater_microcode_rom
    import eater_pkg::*;
(
    input  opcode_t i_opcode,
    input  step_t   i_step,
    input  logic    i_flag_c,
    input  logic    i_flag_z,
    output cw_t     o_ctrl_word
);

    always_comb begin
        o_ctrl_word = '0;
        case (i_step)
            3'd0: o_ctrl_word = cw_bit(CW_MI) | cw_bit(CW_CO);
            3'd1: o_ctrl_word = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
            3'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        o_ctrl_word = cw_bit(CW_IO) | cw_bit(CW_MI);
                    OP_LDI: o_ctrl_word = cw_bit(CW_IO) | cw_bit(CW_AI);
                    OP_JMP: o_ctrl_word = cw_bit(CW_IO) | cw_bit(CW_J);
                    OP_JC:  if (i_flag_c) o_ctrl_word = cw_bit(CW_IO) | cw_bit(CW_J);
                    OP_JZ:  if (i_flag_z) o_ctrl_word = cw_bit(CW_IO) | cw_bit(CW_J);
                    OP_OUT: o_ctrl_word = cw_bit(CW_AO) | cw_bit(CW_OI);
                    OP_HLT: o_ctrl_word = cw_bit(CW_HLT);
                    default: o_ctrl_word = '0;
                endcase
            end
            3'd3: begin
                case (i_opcode)
                    OP_LDA:         o_ctrl_word = cw_bit(CW_RO) | cw_bit(CW_AI);
                    OP_ADD, OP_SUB: o_ctrl_word = cw_bit(CW_RO) | cw_bit(CW_BI);
                    OP_STA:         o_ctrl_word = cw_bit(CW_AO) | cw_bit(CW_RI);
                    default:        o_ctrl_word = '0;
                endcase
            end
            3'd4: begin
                case (i_opcode)
                    OP_ADD:  o_ctrl_word = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                    OP_SUB:  o_ctrl_word = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_SU)
                                         | cw_bit(CW_FI);
                    default: o_ctrl_word = '0;
                endcase
            end
            default: o_ctrl_word = '0;
        endcase
    end

endmodule

// File: rtl/eater_control_sequencer.sv
// T-state sequencer: step counter, HLT latch and program-mode freeze around the microcode ROM.
module eater_control_sequencer
    import eater_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int NUM_STEPS = 5
) (
    input  logic        fastClk,
    input  logic        rst,
    input  logic        step_en,
    input  logic        prog_mode,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl_word,
    output logic [2:0]  step,
    output logic        halted,
    output logic        instr_done
);

    localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

    seq_state_t r_state, w_next_state;
    step_t      r_step,  w_next_step;
    logic       r_done,  w_next_done;

    opcode_t w_opcode;
    step_t   w_step_ahead;
    cw_t     w_cw_cur;
    cw_t     w_cw_ahead;

    assign w_opcode     = opcode_t'(opcode);
    assign w_step_ahead = step_t'(r_step + 3'd1);

    eater_microcode_rom u_rom_cur (
        .i_opcode    (w_opcode),
        .i_step      (r_step),
        .i_flag_c    (flag_c),
        .i_flag_z    (flag_z),
        .o_ctrl_word (w_cw_cur)
    );

    // Lookahead copy decides whether the remaining T-states are empty.
    eater_microcode_rom u_rom_ahead (
        .i_opcode    (w_opcode),
        .i_step      (w_step_ahead),
        .i_flag_c    (flag_c),
        .i_flag_z    (flag_z),
        .o_ctrl_word (w_cw_ahead)
    );

    always_ff @(posedge fastClk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
            r_done  <= w_next_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        w_next_done  = 1'b0;
        if (prog_mode) begin
            w_next_state = S_RUN;
            w_next_step  = '0;
        end else if (step_en && r_state == S_RUN) begin
            // HLT takes priority over wrap so step parks on the HLT T-state.
            if (w_cw_cur[CW_HLT]) begin
                w_next_state = S_HALT;
            end else if (r_step == LAST_STEP || (EARLY_END && w_cw_ahead == '0)) begin
                w_next_step = '0;
                w_next_done = 1'b1;
            end else begin
                w_next_step = w_step_ahead;
            end
        end
    end

    always_comb begin
        ctrl_word = w_cw_cur;
        if (prog_mode)
            ctrl_word = '0;
        else if (r_state == S_HALT)
            ctrl_word = cw_bit(CW_HLT);
    end

    assign step       = r_step;
    assign halted     = (r_state == S_HALT);
    assign instr_done = r_done;

endmodule

// File: tb/tb_eater_control_sequencer.sv
// Table-driven bench for the eater sequencer with a post-edge scoreboard.
module tb_eater_control_sequencer;

    logic        fastClk = 1'b0;
    logic        rst;
    logic        step_en;
    logic        prog_mode;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        halted;
    logic        instr_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        prog;
        logic        en;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] cw_pre;   // word expected after inputs settle, before the edge
        logic [2:0]  step;     // state expected after the edge
        logic        done;
        logic        halt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    eater_control_sequencer #(.EARLY_END(1'b1), .NUM_STEPS(5)) dut (
        .fastClk    (fastClk),
        .rst        (rst),
        .step_en    (step_en),
        .prog_mode  (prog_mode),
        .opcode     (opcode),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .ctrl_word  (ctrl_word),
        .step       (step),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 fastClk = ~fastClk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic void add(input logic prog, input logic en, input logic [3:0] op,
                                input logic c, input logic z, input logic [15:0] cw,
                                input logic [2:0] st, input logic dn, input logic h);
        vec_t v;
        v.prog = prog; v.en = en; v.op = op; v.c = c; v.z = z;
        v.cw_pre = cw; v.step = st; v.done = dn; v.halt = h;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic [3:0] op, input logic [15:0] cw,
                                 input logic [2:0] st, input int n);
        for (int k = 0; k < n; k++) add(0, 0, op, 0, 0, cw, st, 0, 0);
    endfunction

    task automatic pulse_en(input logic [3:0] op);
        @(negedge fastClk);
        opcode = op; step_en = 1'b1; prog_mode = 1'b0;
        @(negedge fastClk);
        step_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; step_en = 1'b0; prog_mode = 1'b0;
        opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        repeat (2) @(posedge fastClk);
        #1;
        chk("reset_step", 16'(step), 16'd0);
        chk("reset_halted", 16'(halted), 16'd0);
        chk("reset_done", 16'(instr_done), 16'd0);
        chk("reset_cw", ctrl_word, 16'h4004);
        @(negedge fastClk);
        rst = 1'b0;

        // LDA, step_en every 4th cycle, early end after T3
        add(0, 1, 4'h1, 0, 0, 16'h4004, 3'd1, 0, 0); idle(4'h1, 16'h1408, 3'd1, 3);
        add(0, 1, 4'h1, 0, 0, 16'h1408, 3'd2, 0, 0); idle(4'h1, 16'h4800, 3'd2, 3);
        add(0, 1, 4'h1, 0, 0, 16'h4800, 3'd3, 0, 0); idle(4'h1, 16'h1200, 3'd3, 3);
        add(0, 1, 4'h1, 0, 0, 16'h1200, 3'd0, 1, 0);
        add(0, 0, 4'h1, 0, 0, 16'h4004, 3'd0, 0, 0);
        // ADD and SUB run all five T-states
        add(0, 1, 4'h2, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h4800, 3'd3, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h1020, 3'd4, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h0281, 3'd0, 1, 0);
        add(0, 1, 4'h3, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h3, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'h3, 0, 0, 16'h4800, 3'd3, 0, 0);
        add(0, 1, 4'h3, 0, 0, 16'h1020, 3'd4, 0, 0);
        add(0, 1, 4'h3, 0, 0, 16'h02C1, 3'd0, 1, 0);
        // JC not taken / taken
        add(0, 1, 4'h7, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h7, 0, 0, 16'h1408, 3'd0, 1, 0);
        add(0, 1, 4'h7, 1, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h7, 1, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'h7, 1, 0, 16'h0802, 3'd0, 1, 0);
        // JZ with zero flag toggling: word and early-end follow the live flag
        add(0, 1, 4'h8, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h8, 0, 1, 16'h1408, 3'd2, 0, 0);
        add(0, 0, 4'h8, 0, 0, 16'h0000, 3'd2, 0, 0);
        add(0, 1, 4'h8, 0, 1, 16'h0802, 3'd0, 1, 0);
        // LDI, JMP, OUT, NOP, unused opcode
        add(0, 1, 4'h5, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h5, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'h5, 0, 0, 16'h0A00, 3'd0, 1, 0);
        add(0, 1, 4'h6, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h6, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'h6, 0, 0, 16'h0802, 3'd0, 1, 0);
        add(0, 1, 4'hE, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'hE, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'hE, 0, 0, 16'h0110, 3'd0, 1, 0);
        add(0, 1, 4'h0, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h1408, 3'd0, 1, 0);
        add(0, 1, 4'hA, 1, 1, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'hA, 1, 1, 16'h1408, 3'd0, 1, 0);
        // HLT latches, ignores step_en, cleared by one cycle of prog_mode
        add(0, 1, 4'hF, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'hF, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'hF, 0, 0, 16'h8000, 3'd2, 0, 1);
        add(0, 1, 4'hF, 0, 0, 16'h8000, 3'd2, 0, 1);
        add(0, 1, 4'h1, 0, 0, 16'h8000, 3'd2, 0, 1);
        add(1, 0, 4'hF, 0, 0, 16'h0000, 3'd0, 0, 0);
        add(0, 0, 4'h4, 0, 0, 16'h4004, 3'd0, 0, 0);
        // STA interrupted at T3 by prog_mode, step_en ignored, resume at T0
        add(0, 1, 4'h4, 0, 0, 16'h4004, 3'd1, 0, 0);
        add(0, 1, 4'h4, 0, 0, 16'h1408, 3'd2, 0, 0);
        add(0, 1, 4'h4, 0, 0, 16'h4800, 3'd3, 0, 0);
        add(0, 0, 4'h4, 0, 0, 16'h2100, 3'd3, 0, 0);
        add(1, 1, 4'h4, 0, 0, 16'h0000, 3'd0, 0, 0);
        add(1, 1, 4'h4, 0, 0, 16'h0000, 3'd0, 0, 0);
        add(0, 0, 4'h4, 0, 0, 16'h4004, 3'd0, 0, 0);
        add(0, 1, 4'h4, 0, 0, 16'h4004, 3'd1, 0, 0);
        // prog_mode and step_en together from T1: no advance
        add(1, 1, 4'h4, 0, 0, 16'h0000, 3'd0, 0, 0);

        foreach (vecs[i]) begin
            vec_t e;
            @(negedge fastClk);
            prog_mode = vecs[i].prog; step_en = vecs[i].en; opcode = vecs[i].op;
            flag_c = vecs[i].c; flag_z = vecs[i].z;
            sb.push_back(vecs[i]);
            #1;
            chk($sformatf("v%0d_cw", i), ctrl_word, vecs[i].cw_pre);
            @(posedge fastClk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_step", i), 16'(step), 16'(e.step));
            chk($sformatf("v%0d_done", i), 16'(instr_done), 16'(e.done));
            chk($sformatf("v%0d_halt", i), 16'(halted), 16'(e.halt));
        end

        // Async reset mid-instruction, no clock edge needed
        @(negedge fastClk);
        prog_mode = 1'b0; step_en = 1'b0; flag_c = 1'b0; flag_z = 1'b0;
        pulse_en(4'h1);
        pulse_en(4'h1);
        chk("pre_rst_step", 16'(step), 16'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_step", 16'(step), 16'd0);
        chk("async_rst_cw", ctrl_word, 16'h4004);
        rst = 1'b0;

        // Async reset clears halt
        pulse_en(4'hF);
        pulse_en(4'hF);
        pulse_en(4'hF);
        chk("pre_rst_halted", 16'(halted), 16'd1);
        chk("pre_rst_halt_cw", ctrl_word, 16'h8000);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_halted", 16'(halted), 16'd0);
        chk("async_rst_halt_step", 16'(step), 16'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
